dccm_mem: RTL

- Data closely-coupled memory (DCCM): the responder side of the LSU's DCCM read and write ports.
- Provides a single-clock, word-organised storage array.
- Reads have a fixed 1-cycle registered latency. Writes are full-word; the LSU performs its own byte/half merge.
- Includes a post-reset zero-clear sequencer and out-of-range error reporting. Sits between the LSU and nothing else: it is the data memory endpoint.

---
 rtl/dccm_mem.sv | 68 ++++++
 1 files changed

// File: rtl/dccm_mem.sv
// dccm_mem: word-organised data memory with 1-cycle reads, post-reset zero clear and range errors
module dccm_mem #(
  parameter int XLEN = 32,
  parameter int DEPTH = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lsu_dccm_raddr,
  input  logic            lsu_dccm_rvalid_in,
  output logic [XLEN-1:0] lsu_dccm_rdata,
  output logic            lsu_dccm_rvalid_out,
  input  logic [XLEN-1:0] lsu_dccm_waddr,
  input  logic            lsu_dccm_wen,
  input  logic [XLEN-1:0] lsu_dccm_wdata,
  output logic            dccm_ready,
  output logic            dccm_rerr,
  output logic            dccm_werr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  logic [0:0] state;
  logic [AW-1:0] cnt, ridx, widx;
  logic [XLEN-1:0] roff, woff;
  logic [XLEN-1:0] mem [DEPTH];
  logic rin, win, rd, wr, clr, last;
  logic unused_low_bits;
  assign roff = lsu_dccm_raddr - BASE_ADDR;
  assign woff = lsu_dccm_waddr - BASE_ADDR;
  assign ridx = roff[AW+1:2];
  assign widx = woff[AW+1:2];
  assign rin = (lsu_dccm_raddr >= BASE_ADDR) && ((roff >> (AW + 2)) == '0);
  assign win = (lsu_dccm_waddr >= BASE_ADDR) && ((woff >> (AW + 2)) == '0);
  assign unused_low_bits = ^{roff[1:0], woff[1:0]};
  assign clr = (state == CLEAR);
  assign last = (cnt == AW'(DEPTH - 1));
  assign rd = dccm_ready & lsu_dccm_rvalid_in;
  assign wr = dccm_ready & lsu_dccm_wen & win;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt <= '0;
      dccm_ready <= 1'b0;
      lsu_dccm_rvalid_out <= 1'b0;
      lsu_dccm_rdata <= '0;
      dccm_rerr <= 1'b0;
      dccm_werr <= 1'b0;
    end else begin
      state <= (clr && last) ? READY : state;
      cnt <= clr ? cnt + 1'b1 : cnt;
      dccm_ready <= !clr || last;
      lsu_dccm_rvalid_out <= rd;
      dccm_rerr <= rd & !rin;
      dccm_werr <= dccm_ready & lsu_dccm_wen & !win;
      if (rd)
        lsu_dccm_rdata <= !rin ? '0 : (wr && widx == ridx) ? lsu_dccm_wdata : mem[ridx];
    end
  end
  // storage has no reset; the clear sequencer zeroes it instead
  always_ff @(posedge clk) begin
    if (!rst && clr)
      mem[cnt] <= '0;
    else if (!rst && wr)
      mem[widx] <= lsu_dccm_wdata;
  end
endmodule
